fifo_uart_tx: RTL and testbench

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

---
 rtl/fifo_uart_pkg.sv | 21 ++
 rtl/fifo_uart_tx_fifo.sv | 60 ++++++
 rtl/fifo_uart_tx.sv | 190 +++++++++++++++++++
 tb/tb_fifo_uart_tx.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_uart_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter: TX FSM state
// encodings and default parameter values.
// Optional feature macro: FIFO_UART_PARITY_EN (adds an even-parity bit).
package fifo_uart_pkg;

  localparam int DEF_DATA_BITS    = 8;
  localparam int DEF_FIFO_DEPTH   = 16;
  localparam int DEF_CLKS_PER_BIT = 87;
  localparam int DEF_STOP_BITS    = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef FIFO_UART_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } tx_state_e;

endpackage

// File: rtl/fifo_uart_tx_fifo.sv
// sync_fifo: circular single-clock FIFO with occupancy count, full/empty
// flags and a registered overflow pulse for dropped writes.
// Storage is deliberately left out of reset; only pointers and count clear.
module sync_fifo
  import fifo_uart_pkg::*;
#(
  parameter int WIDTH = DEF_DATA_BITS,
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             wr_acc;
  logic             rd_acc;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign wr_acc  = wr_en & ~full;
  assign rd_acc  = rd_en & ~empty;
  assign rd_data = mem[rd_ptr];

  // Storage write; no reset so the array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally (power-of-two depth); count tracks net push/pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= wr_en & full;
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: FIFO-buffered UART transmitter. Frames are sent back to
// back while the FIFO holds data; Tx_Serial is registered.
// Optional feature macro: FIFO_UART_PARITY_EN (even-parity bit after data).
//
// state  | meaning
// IDLE   | line high, waiting for FIFO data
// START  | start bit (low)
// DATA   | data bits, LSB first
// PARITY | even parity of the data bits (macro builds only)
// STOP   | stop bit(s), high; Tx_Done on the final cycle
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int DATA_BITS    = DEF_DATA_BITS,
  parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH,
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int STOP_BITS    = DEF_STOP_BITS
) (
  input  logic                        Clock,
  input  logic                        Reset,
  input  logic                        Wr_En,
  input  logic [DATA_BITS-1:0]        Wr_Data,
  output logic                        Wr_Overflow,
  output logic                        f_full,
  output logic                        f_empty,
  output logic [$clog2(FIFO_DEPTH):0] f_count,
  output logic                        Tx_Serial,
  output logic                        Tx_Active,
  output logic                        Tx_Done
);

  // Cycle counter must reach STOP_BITS*CLKS_PER_BIT-1, the longest phase.
  localparam int STOP_CLKS = STOP_BITS * CLKS_PER_BIT;
  localparam int CNT_W     = $clog2(STOP_CLKS);
  localparam int BIT_W     = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] BIT_RELOAD  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] STOP_RELOAD = CNT_W'(STOP_CLKS - 1);
  localparam logic [BIT_W-1:0] LAST_BIT    = BIT_W'(DATA_BITS - 1);

  tx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 serial_q, serial_d;
  logic                 pop;
  logic [DATA_BITS-1:0] fifo_rd_data;
`ifdef FIFO_UART_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (Clock),
    .rst      (Reset),
    .wr_en    (Wr_En),
    .wr_data  (Wr_Data),
    .rd_en    (pop),
    .rd_data  (fifo_rd_data),
    .full     (f_full),
    .empty    (f_empty),
    .count    (f_count),
    .overflow (Wr_Overflow)
  );

  assign Tx_Serial = serial_q;
  assign Tx_Active = (state_q != ST_IDLE);
  assign Tx_Done   = (state_q == ST_STOP) && (cnt_q == '0);

  // State and datapath registers; reset aborts any frame in flight.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      serial_q <= 1'b1;
`ifdef FIFO_UART_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      serial_q <= serial_d;
`ifdef FIFO_UART_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  // Next-state, next line level and FIFO pop; line level is registered so
  // it changes on the same edge as the state.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    serial_d = serial_q;
    pop      = 1'b0;
`ifdef FIFO_UART_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      ST_IDLE: begin
        serial_d = 1'b1;
        if (!f_empty) begin
          pop      = 1'b1;
          shift_d  = fifo_rd_data;
          state_d  = ST_START;
          cnt_d    = BIT_RELOAD;
          serial_d = 1'b0;
`ifdef FIFO_UART_PARITY_EN
          parity_d = ^fifo_rd_data;
`endif
        end
      end
      ST_START: begin
        if (cnt_q == '0) begin
          state_d  = ST_DATA;
          cnt_d    = BIT_RELOAD;
          bit_d    = LAST_BIT;
          serial_d = shift_q[0];
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DATA: begin
        if (cnt_q == '0) begin
          shift_d = shift_q >> 1;
          if (bit_q == '0) begin
`ifdef FIFO_UART_PARITY_EN
            state_d  = ST_PARITY;
            cnt_d    = BIT_RELOAD;
            serial_d = parity_q;
`else
            state_d  = ST_STOP;
            cnt_d    = STOP_RELOAD;
            serial_d = 1'b1;
`endif
          end else begin
            bit_d    = bit_q - 1'b1;
            cnt_d    = BIT_RELOAD;
            serial_d = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
`ifdef FIFO_UART_PARITY_EN
      ST_PARITY: begin
        if (cnt_q == '0) begin
          state_d  = ST_STOP;
          cnt_d    = STOP_RELOAD;
          serial_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
`endif
      ST_STOP: begin
        if (cnt_q == '0) begin
          if (!f_empty) begin
            pop      = 1'b1;
            shift_d  = fifo_rd_data;
            state_d  = ST_START;
            cnt_d    = BIT_RELOAD;
            serial_d = 1'b0;
`ifdef FIFO_UART_PARITY_EN
            parity_d = ^fifo_rd_data;
`endif
          end else begin
            state_d  = ST_IDLE;
            serial_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        serial_d = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: frame-level reference model plus line monitor.
module tb_fifo_uart_tx;

  localparam int DBITS = 8;
  localparam int DEPTH = 4;
  localparam int CPB   = 4;
  localparam int SBITS = 1;
`ifdef FIFO_UART_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int NBITS = 1 + DBITS + (PAR ? 1 : 0) + SBITS;
  localparam int FRAME = NBITS * CPB;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             wr_en = 1'b0;
  logic [DBITS-1:0] wr_data = '0;
  logic             Wr_Overflow, f_full, f_empty, Tx_Serial, Tx_Active, Tx_Done;
  logic [2:0]       f_count;

  fifo_uart_tx #(
    .DATA_BITS    (DBITS),
    .FIFO_DEPTH   (DEPTH),
    .CLKS_PER_BIT (CPB),
    .STOP_BITS    (SBITS)
  ) dut (
    .Clock       (clk),
    .Reset       (rst),
    .Wr_En       (wr_en),
    .Wr_Data     (wr_data),
    .Wr_Overflow (Wr_Overflow),
    .f_full      (f_full),
    .f_empty     (f_empty),
    .f_count     (f_count),
    .Tx_Serial   (Tx_Serial),
    .Tx_Active   (Tx_Active),
    .Tx_Done     (Tx_Done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      if (errors < 40) $display("FAIL %s got=%0d expected=%0d t=%0t", name, act, req, $time);
    end
  endtask

  // Reference model: FIFO contents as a queue, plus remaining cycles of the
  // frame on the line. A new frame may start when the line is idle or on
  // the last cycle of the current frame.
  logic [DBITS-1:0] mq[$];
  logic [DBITS-1:0] exp_q[$];
  int  rem = 0;
  bit  m_ovf = 1'b0;
  bit  m_acc, m_pop;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      exp_q.delete();
      rem   = 0;
      m_ovf = 1'b0;
    end else begin
      m_ovf = wr_en && (mq.size() == DEPTH);
      m_acc = wr_en && (mq.size() < DEPTH);
      m_pop = (mq.size() != 0) && (rem <= 1);
      if (m_pop) begin
        exp_q.push_back(mq.pop_front());
        rem = FRAME;
      end else if (rem > 0) begin
        rem--;
      end
      if (m_acc) mq.push_back(wr_data);
    end
  end

  function automatic logic [63:0] mk_line(input logic [DBITS-1:0] b);
    logic [63:0] l;
    int bi;
    l = '0;
    for (int i = 0; i < FRAME; i++) begin
      bi = i / CPB;
      if (bi == 0)                  l[i] = 1'b0;
      else if (bi <= DBITS)         l[i] = b[bi-1];
      else if (PAR && bi == DBITS+1) l[i] = ^b;
      else                          l[i] = 1'b1;
    end
    return l;
  endfunction

  // Monitor: compares flags against the model each cycle and captures the
  // serial line frame by frame, checking it against the popped byte.
  int          mon_pos = 0;
  logic [63:0] ln = '0;
  logic [63:0] expl;
  logic [DBITS-1:0] eb;
  int          frames_seen = 0;

  always @(negedge clk) begin
    if (rst) begin
      mon_pos = 0;
      chk("rst_serial", int'(Tx_Serial), 1);
      chk("rst_active", int'(Tx_Active), 0);
      chk("rst_done", int'(Tx_Done), 0);
      chk("rst_ovf", int'(Wr_Overflow), 0);
      chk("rst_empty", int'(f_empty), 1);
      chk("rst_full", int'(f_full), 0);
      chk("rst_count", int'(f_count), 0);
    end else begin
      chk("f_count", int'(f_count), mq.size());
      chk("f_empty", int'(f_empty), int'(mq.size() == 0));
      chk("f_full", int'(f_full), int'(mq.size() == DEPTH));
      chk("wr_overflow", int'(Wr_Overflow), int'(m_ovf));
      chk("tx_active", int'(Tx_Active), int'(rem != 0));
      if (mon_pos == 0 && !Tx_Active) begin
        chk("idle_line", int'(Tx_Serial), 1);
        chk("idle_done", int'(Tx_Done), 0);
      end else begin
        if (mon_pos == 0) ln = '0;
        ln[mon_pos] = Tx_Serial;
        chk("done_pos", int'(Tx_Done), int'(mon_pos == FRAME-1));
        mon_pos++;
        if (mon_pos == FRAME) begin
          mon_pos = 0;
          frames_seen++;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL frame_unexpected got=%h expected=none", ln);
          end else begin
            eb   = exp_q.pop_front();
            expl = mk_line(eb);
            if (ln !== expl) begin
              errors++;
              $display("FAIL frame_bits byte=%h got=%h expected=%h", eb, ln, expl);
            end
          end
        end
      end
    end
  end

  task automatic wr(input logic [DBITS-1:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((mq.size() != 0 || rem != 0) && n < 3000) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (n >= 3000) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout got=%0d expected=<3000", n);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // Single byte and first-frame latency.
    wr(8'hA5);
    chk("lat_empty_n1", int'(f_empty), 0);
    @(posedge clk);
    #1;
    chk("lat_serial_n2", int'(Tx_Serial), 0);
    chk("lat_active_n2", int'(Tx_Active), 1);
    drain();

    // Back-to-back frames.
    wr(8'h01);
    wr(8'h02);
    wr(8'h03);
    drain();

    // Overflow while the transmitter is busy.
    wr(8'hC3);
    repeat (3) @(posedge clk);
    #1;
    wr(8'h11);
    wr(8'h22);
    wr(8'h33);
    wr(8'h44);
    wr(8'h55);
    chk("ovf_pulse", int'(Wr_Overflow), 1);
    chk("ovf_full", int'(f_full), 1);
    @(posedge clk);
    #1;
    chk("ovf_one_cycle", int'(Wr_Overflow), 0);
    drain();

    // Parity-relevant patterns.
    wr(8'h07);
    wr(8'h03);
    drain();

    // Random traffic: heavy (overflows) then light (pointer wrap).
    for (int i = 0; i < 400; i++) begin
      wr_en   = ($urandom_range(0, 99) < ((i < 200) ? 12 : 3));
      wr_data = DBITS'($urandom);
      @(posedge clk);
      #1;
    end
    wr_en = 1'b0;
    drain();

    // Reset in the middle of the data bits.
    wr(8'h3C);
    repeat (10) @(posedge clk);
    #1;
    wr(8'h99);
    rst = 1'b1;
    #1;
    chk("mid_rst_serial", int'(Tx_Serial), 1);
    chk("mid_rst_empty", int'(f_empty), 1);
    chk("mid_rst_done", int'(Tx_Done), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    wr(8'h55);
    drain();

    chk("end_pending_frames", exp_q.size(), 0);
    chk("end_fifo_model", mq.size(), 0);
    chk("frames_seen_nonzero", int'(frames_seen > 20), 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
